fp_sign_resolve_pipe: RTL and testbench
=======================================

Name: fp_sign_resolve_pipe

Overview:
- Final sign/special-case resolution stage for the FPU add/sub datapath, generalised to any IEEE-style format width.
- Takes operands, the unsigned magnitude result and the magnitude compare, then produces the signed result.
- Handles effective subtraction, exact-cancellation zero sign per rounding direction, and infinities.
- Registered over a parametrised number of pipeline stages with valid/ready backpressure; sits between the normaliser and the FPU writeback.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, mantissa field width; FP_W = 1+EXP_W+MAN_W.
- STAGES, 2, pipeline depth; legal range 1..4; latency in cycles.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  stage can accept a beat this cycle.
- op_sub  input  1  1 = a-b, 0 = a+b.
- rdn_mode  input  1  rounding mode is round-down (affects zero sign only).
- fp_a  input  FP_W  operand a.
- fp_b  input  FP_W  operand b, before op_sub sign flip.
- mag_result  input  FP_W-1  unsigned exponent/mantissa result.
- b_mag_gt  input  1  1 when |b| > |a|.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- fp_out  output  FP_W  signed result.
- cancel_zero  output  1  result is an exact-cancellation zero.

Behaviour:
- Effective b sign: sb = fp_b[FP_W-1] ^ op_sub; sa = fp_a[FP_W-1].
- Sign rules, evaluated combinationally on accepted input, first match wins:
  - sa == sb: sign = sa.
  - sa != sb and mag_result == 0: sign = rdn_mode, cancel_zero = 1.
  - sa != sb: sign = b_mag_gt ? sb : sa.
- Infinity, exponent all ones and mantissa zero:
  - Exactly one operand infinite: output is that operand with its effective sign.
  - Both infinite with equal effective sign: output is that infinity.
  - Both infinite with opposite effective signs: handled per the optional feature.
- fp_out = {sign, mag_result} unless overridden above; cancel_zero = 0 unless set above.
- Pipeline: STAGES register slices, each holding valid, fp_out and cancel_zero. Resolution is computed before slice 0.
- Global advance = !out_valid || out_ready. in_ready = advance, combinational.
- When advance = 1, every slice shifts one position and slice 0 loads {in_valid, resolved data}. When advance = 0, all slices hold.
- A beat is accepted iff in_valid && in_ready. A beat is delivered iff out_valid && out_ready.
- Latency is exactly STAGES cycles with no stalls. Throughput is 1 beat/cycle while out_ready = 1.
- Data registers update only on advance. Contents of invalid slices are don't-care but must not be X after reset.
- Reset, asynchronous on nRST low:
  - All valid bits = 0, out_valid = 0, fp_out = 0, cancel_zero = 0.
  - in_ready = 1 immediately.
  - In-flight beats are discarded. No beat is emitted on the first edge after reset release unless one was accepted.
- Simultaneous accept and deliver at the same edge when full: both occur and there is no bubble.
- out_ready low with a full pipe: in_ready = 0, and fp_out/out_valid stay stable until delivered.
- Inputs are sampled only on the accept edge; changes while in_ready = 0 are ignored.

Optional Feature:
- Macro: FP_SIGN_NAN_EN.
- Defined:
  - Any NaN operand (exponent all ones, mantissa nonzero), or opposite-effective-sign infinities, outputs canonical quiet NaN {0, all-ones exp, 1 followed by zeros}.
  - Adds output port invalid_flag (1 bit), pipelined alongside the data.
  - invalid_flag = 1 for signalling NaN input (mantissa MSB 0) or inf-inf; reset value 0.
- Undefined:
  - NaN operands get no special handling; output follows the sign rules applied to mag_result.
  - Opposite-effective-sign infinities output {sa, mag_result}.
  - No invalid_flag port.

Test Plan:
- Reset check: nRST low mid-stream with 2 beats in flight -> out_valid = 0, fp_out = 0, in_ready = 1; no stale beat after release.
- Sign cases, defaults, 0x3F800000 + 0xC0000000 (1.0 + -2.0), b_mag_gt = 1, mag_result = 0x3F800000 -> fp_out = 0xBF800000 after exactly 2 cycles.
- Cancellation: a = 0x40400000, b = 0x40400000, op_sub = 1, mag_result = 0 -> fp_out = 0x00000000, cancel_zero = 1; same with rdn_mode = 1 -> 0x80000000.
- Backpressure: stream 6 beats with out_ready toggling 1,0,0,1,... -> all 6 delivered in order, none lost or duplicated, fp_out stable while stalled, in_ready = 0 whenever pipe full and out_ready = 0.
- Infinity: a = 0x7F800000, b = 0x7F800000, op_sub = 1 -> with FP_SIGN_NAN_EN: fp_out = 0x7FC00000, invalid_flag = 1; without: fp_out = {0, mag_result}.
- STAGES = 1 and STAGES = 4 builds: back-to-back 10 beats with out_ready = 1 -> latency 1 and 4 respectively, 1 beat/cycle throughput.

Source files
------------

// File: rtl/fp_sign_resolve_pipe.sv
// fp_sign_resolve_pipe: final sign / special-case resolution for the FPU
// add/sub path, followed by a STAGES-deep valid/ready register pipeline.
//
// Ports:
//   CLK, nRST            clock (rising edge), async active-low reset
//   in_valid/in_ready    input handshake (in_ready = pipeline advance)
//   op_sub, rdn_mode     subtract select, round-down mode (zero sign)
//   fp_a, fp_b           operands (fp_b before the op_sub sign flip)
//   mag_result           unsigned exponent/mantissa result
//   b_mag_gt             |b| > |a|
//   out_valid/out_ready  output handshake
//   fp_out, cancel_zero  signed result, exact-cancellation zero flag
//   invalid_flag         only when FP_SIGN_NAN_EN is defined
//
// Optional feature macro: FP_SIGN_NAN_EN (NaN handling + invalid_flag).
module fp_sign_resolve_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 2,
    localparam int FP_W  = 1 + EXP_W + MAN_W
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            op_sub,
    input  logic            rdn_mode,
    input  logic [FP_W-1:0] fp_a,
    input  logic [FP_W-1:0] fp_b,
    input  logic [FP_W-2:0] mag_result,
    input  logic            b_mag_gt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] fp_out,
    output logic            cancel_zero
`ifdef FP_SIGN_NAN_EN
    ,
    output logic            invalid_flag
`endif
);

    logic             sa;
    logic             sb;
    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
    logic [MAN_W-1:0] ma;
    logic [MAN_W-1:0] mb;
    logic             a_inf;
    logic             b_inf;
    logic             a_nan;
    logic             b_nan;

    assign sa    = fp_a[FP_W-1];
    assign sb    = fp_b[FP_W-1] ^ op_sub;
    assign ea    = fp_a[FP_W-2:MAN_W];
    assign eb    = fp_b[FP_W-2:MAN_W];
    assign ma    = fp_a[MAN_W-1:0];
    assign mb    = fp_b[MAN_W-1:0];
    assign a_inf = (&ea) && !(|ma);
    assign b_inf = (&eb) && !(|mb);
    assign a_nan = (&ea) && (|ma);
    assign b_nan = (&eb) && (|mb);

    logic            sign_d;
    logic [FP_W-1:0] dat_d;
    logic            cz_d;
    logic            inv_d;

    always_comb begin
        sign_d = sa;
        cz_d   = 1'b0;
        inv_d  = 1'b0;
        if (sa == sb) begin
            sign_d = sa;
        end else if (mag_result == '0) begin
            sign_d = rdn_mode;
            cz_d   = 1'b1;
        end else begin
            sign_d = b_mag_gt ? sb : sa;
        end
        dat_d = {sign_d, mag_result};
`ifdef FP_SIGN_NAN_EN
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            dat_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            cz_d  = 1'b0;
            // quiet NaN inputs propagate silently; sNaN and inf-inf raise
            inv_d = (a_nan && !ma[MAN_W-1]) ||
                    (b_nan && !mb[MAN_W-1]) ||
                    (a_inf && b_inf);
        end else
`endif
        if (a_inf && b_inf) begin
            // opposite signs fall back to the magnitude path
            dat_d = (sa == sb) ? {sa, fp_a[FP_W-2:0]}
                               : {sa, mag_result};
            cz_d  = 1'b0;
        end else if (a_inf) begin
            dat_d = {sa, fp_a[FP_W-2:0]};
            cz_d  = 1'b0;
        end else if (b_inf) begin
            dat_d = {sb, fp_b[FP_W-2:0]};
            cz_d  = 1'b0;
        end
    end

    logic                             adv;
    logic [STAGES-1:0]                vld_q;
    logic [STAGES-1:0][FP_W-1:0]      dat_q;
    logic [STAGES-1:0]                cz_q;
    logic [STAGES-1:0]                inv_q;

    // whole pipe moves as one; a stall at the output freezes every slice
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[STAGES-1];
    assign fp_out    = dat_q[STAGES-1];
    assign cancel_zero = cz_q[STAGES-1];
`ifdef FP_SIGN_NAN_EN
    assign invalid_flag = inv_q[STAGES-1];
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            vld_q <= '0;
            dat_q <= '0;
            cz_q  <= '0;
            inv_q <= '0;
        end else if (adv) begin
            vld_q[0] <= in_valid;
            dat_q[0] <= dat_d;
            cz_q[0]  <= cz_d;
            inv_q[0] <= inv_d;
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
                cz_q[i]  <= cz_q[i-1];
                inv_q[i] <= inv_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_fp_sign_resolve_pipe.sv
// tb_fp_sign_resolve_pipe: directed + random checks of fp_sign_resolve_pipe
// against a rule-level reference model and an in-order scoreboard queue.
module tb_fp_sign_resolve_pipe;

    localparam int EW  = 8;
    localparam int MW  = 23;
    localparam int STG = 2;
    localparam int FW  = 1 + EW + MW;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          in_valid = 1'b0;
    logic          op_sub = 1'b0;
    logic          rdn_mode = 1'b0;
    logic          b_mag_gt = 1'b0;
    logic          out_ready = 1'b1;
    logic [FW-1:0] fp_a = '0;
    logic [FW-1:0] fp_b = '0;
    logic [FW-2:0] mag_result = '0;
    logic          in_ready;
    logic          out_valid;
    logic          cancel_zero;
    logic [FW-1:0] fp_out;
`ifdef FP_SIGN_NAN_EN
    logic          invalid_flag;
`endif

    fp_sign_resolve_pipe #(.EXP_W(EW), .MAN_W(MW), .STAGES(STG)) dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_sub(op_sub), .rdn_mode(rdn_mode),
        .fp_a(fp_a), .fp_b(fp_b),
        .mag_result(mag_result), .b_mag_gt(b_mag_gt),
        .out_valid(out_valid), .out_ready(out_ready),
        .fp_out(fp_out), .cancel_zero(cancel_zero)
`ifdef FP_SIGN_NAN_EN
        , .invalid_flag(invalid_flag)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [FW-1:0] fp;
        logic          cz;
        logic          inv;
        int            acc;
    } beat_t;

    beat_t         q[$];
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    bit            chk_lat = 0;
    int            rmode = 0;
    int            rp = 0;
    logic [FW-1:0] last_out = '0;
    logic          last_cz = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: classify operands, then apply the rule list in order.
    function automatic beat_t model(input logic [FW-1:0] a, b,
                                    input logic sub, rdn,
                                    input logic [FW-2:0] mag,
                                    input logic gt);
        beat_t r;
        logic  s, xa, xb;
        bit    ai, bi, an, bn;
        xa = a[FW-1];
        xb = b[FW-1] ^ sub;
        ai = (a[FW-2:MW] == {EW{1'b1}}) && (a[MW-1:0] == 0);
        bi = (b[FW-2:MW] == {EW{1'b1}}) && (b[MW-1:0] == 0);
        an = (a[FW-2:MW] == {EW{1'b1}}) && (a[MW-1:0] != 0);
        bn = (b[FW-2:MW] == {EW{1'b1}}) && (b[MW-1:0] != 0);
        r.cz = 0;
        r.inv = 0;
        r.acc = 0;
        if (xa == xb) s = xa;
        else if (mag == 0) begin s = rdn; r.cz = 1; end
        else s = gt ? xb : xa;
        r.fp = {s, mag};
`ifdef FP_SIGN_NAN_EN
        if (an || bn || (ai && bi && xa != xb)) begin
            r.fp = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
            r.cz = 0;
            r.inv = (an && !a[MW-1]) || (bn && !b[MW-1]) || (ai && bi);
            return r;
        end
`else
        if (an || bn) r.inv = 0;
`endif
        if (ai && bi) begin
            r.fp = (xa == xb) ? a : {xa, mag};
            r.cz = 0;
        end else if (ai) begin
            r.fp = a;
            r.cz = 0;
        end else if (bi) begin
            r.fp = {xb, b[FW-2:0]};
            r.cz = 0;
        end
        return r;
    endfunction

    task automatic tick(output bit acc);
        beat_t e;
        bit    dlv;
        if (rmode == 1) begin
            out_ready = (rp % 4 == 0) || (rp % 4 == 3);
            rp++;
        end else if (rmode == 2) begin
            out_ready = ($urandom_range(0, 9) < 7);
        end
        @(negedge CLK);
        acc = in_valid && in_ready;
        dlv = out_valid && out_ready;
        if (q.size() == 0) begin
            chk("idle_out_valid", out_valid, 0);
            chk("empty_in_ready", in_ready, 1);
        end else if (out_valid) begin
            chk("data", fp_out, q[0].fp);
            chk("cancel_zero", cancel_zero, q[0].cz);
`ifdef FP_SIGN_NAN_EN
            chk("invalid_flag", invalid_flag, q[0].inv);
`endif
            if (dlv && chk_lat) chk("latency", cyc - q[0].acc + 1, STG);
        end
        if (q.size() == STG && !out_ready) chk("full_stall", in_ready, 0);
        if (dlv) begin
            last_out = fp_out;
            last_cz = cancel_zero;
        end
        e = model(fp_a, fp_b, op_sub, rdn_mode, mag_result, b_mag_gt);
        @(posedge CLK);
        cyc++;
        if (dlv) void'(q.pop_front());
        if (acc) begin
            e.acc = cyc;
            q.push_back(e);
        end
        #1;
    endtask

    task automatic send(input logic [FW-1:0] a, b, input logic sub, rdn,
                        input logic [FW-2:0] mag, input logic gt);
        bit acc;
        fp_a = a; fp_b = b; op_sub = sub; rdn_mode = rdn;
        mag_result = mag; b_mag_gt = gt; in_valid = 1;
        for (int i = 0; i < 50; i++) begin
            tick(acc);
            if (acc) break;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        in_valid = 0;
        fp_a = $urandom; fp_b = $urandom;
    endtask

    task automatic drain();
        bit acc;
        in_valid = 0;
        for (int i = 0; i < 60 && q.size() != 0; i++) tick(acc);
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic send_rand();
        logic [FW-1:0] a, b;
        logic [FW-2:0] m;
        logic          s;
        a = $urandom; b = $urandom; m = $urandom; s = $urandom;
        case ($urandom_range(0, 7))
            0: a = {a[FW-1], {EW{1'b1}}, {MW{1'b0}}};
            1: b = {b[FW-1], {EW{1'b1}}, {MW{1'b0}}};
            2: begin
                a = {a[FW-1], {EW{1'b1}}, {MW{1'b0}}};
                b = {b[FW-1], {EW{1'b1}}, {MW{1'b0}}};
            end
            3: begin b = a; s = 1; m = 0; end
            4: a[FW-2:MW] = {EW{1'b1}};
            5: m = 0;
            default: ;
        endcase
        send(a, b, s, $urandom, m, $urandom);
    endtask

    initial begin
        bit acc;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fp_out", fp_out, 0);
        chk("rst_cancel", cancel_zero, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge CLK); @(posedge CLK); #1;
        nRST = 1;
        tick(acc); tick(acc);

        chk_lat = 1;
        send(32'h3F800000, 32'hC0000000, 0, 0, 31'h3F800000, 1);
        drain();
        chk("sign_lit", last_out, 32'hBF800000);

        send(32'h40400000, 32'h40400000, 1, 0, 31'h0, 0);
        drain();
        chk("cancel_rn_lit", last_out, 32'h00000000);
        chk("cancel_rn_cz", last_cz, 1);

        send(32'h40400000, 32'h40400000, 1, 1, 31'h0, 0);
        drain();
        chk("cancel_rd_lit", last_out, 32'h80000000);

        send(32'h7F800000, 32'h7F800000, 1, 0, 31'h00012345, 0);
        drain();
`ifdef FP_SIGN_NAN_EN
        chk("inf_inf_lit", last_out, 32'h7FC00000);
`else
        chk("inf_inf_lit", last_out, 32'h00012345);
`endif

        send(32'h3F800000, 32'h7F800000, 1, 0, 31'h0055AA00, 1);
        drain();
        chk("one_inf_lit", last_out, 32'hFF800000);
        chk_lat = 0;

        rmode = 1; rp = 0;
        for (int i = 0; i < 6; i++) send_rand();
        drain();
        rmode = 0; out_ready = 1;

        out_ready = 0;
        send(32'h3F800000, 32'h40000000, 0, 0, 31'h40400000, 1);
        send(32'h40000000, 32'h40000000, 0, 0, 31'h40800000, 0);
        #2 nRST = 0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_fp_out", fp_out, 0);
        chk("midrst_in_ready", in_ready, 1);
        q.delete();
        @(posedge CLK); #1;
        nRST = 1;
        out_ready = 1;
        for (int i = 0; i < 4; i++) tick(acc);

        rmode = 2;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 4) == 0) tick(acc);
            else send_rand();
        end
        drain();
        rmode = 0; out_ready = 1;

        chk_lat = 1;
        for (int i = 0; i < 10; i++) send_rand();
        drain();
        chk_lat = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
